// File: rtl/rock_pkg.sv
// Shared types and defaults for the cradle rocking scheduler.
package rock_pkg;

  localparam int FREQ_W    = 4;
  localparam int AMP_W     = 3;
  localparam int F_MIN_DEF = 1;
  localparam int F_MAX_DEF = 15;
  localparam int A_MAX_DEF = 7;

  // State codes are visible on the state output, so the encoding is fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_ROCK   = 2'd2,
    ST_SETTLE = 2'd3
  } rock_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles while run is high.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count; dropping run clears the count so the next run starts fresh.
  always_comb begin
    tick  = run && (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    if (!run || (cnt_q == LAST)) cnt_d = '0;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rock_scheduler.sv
// Cradle rocking scheduler: swing timing, step pulses and command arbitration.
//
// Command inputs are single-cycle request pulses with no handshake: a request
// present on a rising edge is either applied at that edge or dropped for good.
module rock_scheduler
  import rock_pkg::*;
#(
  parameter int TICK_DIV     = 1000,
  parameter int SETTLE_TICKS = 16,
  parameter int F_MIN        = F_MIN_DEF,
  parameter int F_MAX        = F_MAX_DEF,
  parameter int A_MAX        = A_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              man_up,
  input  logic              man_dn,
  input  logic              Fplus,
  input  logic              Fmin,
  input  logic              Amin,
  output logic [FREQ_W-1:0] freq,
  output logic [AMP_W-1:0]  amp,
  output logic              motor_dir,
  output logic              motor_step,
  output logic              busy,
  output logic [1:0]        state
);

  localparam int SET_W = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam logic [FREQ_W-1:0] FMIN_V    = FREQ_W'(F_MIN);
  localparam logic [FREQ_W-1:0] FMAX_V    = FREQ_W'(F_MAX);
  localparam logic [AMP_W-1:0]  AMP_START = (A_MAX >= 1) ? AMP_W'(1) : '0;
  localparam logic [SET_W-1:0]  SETTLE_V  = SET_W'(SETTLE_TICKS);

  rock_state_e       state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [AMP_W-1:0]  amp_q, amp_d;
  // hs_idx counts ticks within the half-swing; hs_end is its last index (F_MAX - freq).
  logic [FREQ_W-1:0] hs_idx_q, hs_idx_d, hs_end_q, hs_end_d;
  logic              dir_q, dir_d, step_q, step_d;
  logic [SET_W-1:0]  settle_q, settle_d;

  logic run, tick, hs_last;
  logic man_req, auto_req, apply_man, apply_auto, applied;
  logic f_up, f_dn, a_dn;

  assign run     = enable && (state_q != ST_IDLE);
  assign hs_last = tick && (hs_idx_q == hs_end_q);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  // Arbitration: manual beats auto; opposing frequency requests cancel but still count as applied.
  always_comb begin
    man_req    = man_up | man_dn;
    auto_req   = Fplus | Fmin | Amin;
    apply_man  = enable && ((state_q == ST_ROCK) || (state_q == ST_SETTLE)) && man_req;
    apply_auto = enable && (state_q == ST_ROCK) && !man_req && auto_req;
    applied    = apply_man | apply_auto;
    f_up       = (apply_man && man_up && !man_dn) || (apply_auto && Fplus && !Fmin);
    f_dn       = (apply_man && man_dn && !man_up) || (apply_auto && Fmin && !Fplus);
    a_dn       = apply_auto && Amin;
  end

  // Saturating setting updates, plus the amplitude kick-start on leaving IDLE.
  always_comb begin
    freq_d = freq_q;
    if (f_up && (freq_q < FMAX_V))      freq_d = freq_q + 1'b1;
    else if (f_dn && (freq_q > FMIN_V)) freq_d = freq_q - 1'b1;
    amp_d = amp_q;
    if (enable && (state_q == ST_IDLE) && (amp_q == '0)) amp_d = AMP_START;
    else if (a_dn && (amp_q != '0))                      amp_d = amp_q - 1'b1;
  end

  // Swing timing: new half-swing length is latched only at a boundary, so freq changes lag.
  always_comb begin
    hs_idx_d = hs_idx_q;
    hs_end_d = hs_end_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    if (!enable || (state_q == ST_IDLE)) begin
      hs_idx_d = '0;
      hs_end_d = FMAX_V - freq_q;
      dir_d    = 1'b0;
    end else if (tick) begin
      step_d = (hs_idx_q < FREQ_W'(amp_q));
      if (hs_last) begin
        hs_idx_d = '0;
        hs_end_d = FMAX_V - freq_q;
        dir_d    = ~dir_q;
      end else begin
        hs_idx_d = hs_idx_q + 1'b1;
      end
    end
  end

  // Settle lockout: any applied command reloads, ticks in SETTLE count down.
  always_comb begin
    settle_d = settle_q;
    if (!enable || (state_q == ST_IDLE))                          settle_d = '0;
    else if (applied)                                             settle_d = SETTLE_V;
    else if ((state_q == ST_SETTLE) && tick && (settle_q != '0))  settle_d = settle_q - 1'b1;
  end

  // FSM next-state logic; enable low overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable)  state_d = ST_START;
      ST_START:  if (hs_last) state_d = ST_ROCK;
      ST_ROCK:   if (applied) state_d = ST_SETTLE;
      ST_SETTLE: if (!apply_man &&
                     ((settle_q == '0) || (tick && (settle_q == SET_W'(1)))))
                   state_d = ST_ROCK;
      default:   state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers; reset clears the pending step so an aborted swing emits nothing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      freq_q   <= FMIN_V;
      amp_q    <= '0;
      hs_idx_q <= '0;
      hs_end_q <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      freq_q   <= freq_d;
      amp_q    <= amp_d;
      hs_idx_q <= hs_idx_d;
      hs_end_q <= hs_end_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      settle_q <= settle_d;
    end
  end

  // FSM and datapath outputs.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    state      = state_q;
    freq       = freq_q;
    amp        = amp_q;
    motor_dir  = dir_q;
    motor_step = step_q;
  end

endmodule

// File: tb/tb_rock_scheduler.sv
// Self-checking bench for rock_scheduler: directed scenarios plus random commands
// against a cycle-level behavioural model of the rocking rules.
module tb_rock_scheduler;

  localparam int TD   = 4;
  localparam int STK  = 2;
  localparam int FMIN = 1;
  localparam int FMAX = 15;
  localparam int EW   = 11;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0, enable = 1'b0;
  logic man_up = 1'b0, man_dn = 1'b0, Fplus = 1'b0, Fmin = 1'b0, Amin = 1'b0;
  logic [3:0] freq;
  logic [2:0] amp;
  logic motor_dir, motor_step, busy;
  logic [1:0] state;

  always #5 clk = ~clk;

  rock_scheduler #(.TICK_DIV(TD), .SETTLE_TICKS(STK)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .man_up(man_up), .man_dn(man_dn), .Fplus(Fplus), .Fmin(Fmin), .Amin(Amin),
    .freq(freq), .amp(amp), .motor_dir(motor_dir), .motor_step(motor_step),
    .busy(busy), .state(state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States: 0 idle, 1 start, 2 rock, 3 settle. Time inside a run is tracked as
  // a plain cycle count; a tick is every TD-th cycle of the run.
  bit m_valid = 1'b0;
  int m_st, m_freq, m_amp, m_dir, m_step;
  int m_cyc, m_len, m_el, m_settle;
  logic [EW-1:0] exp_q[$];

  task automatic model_step();
    bit tick, bound, app_m, app_a, up, dn;
    if (!reset) begin
      m_valid = 1'b1;
      m_st = 0; m_freq = FMIN; m_amp = 0; m_dir = 0; m_step = 0;
      m_cyc = 0; m_len = 0; m_el = 0; m_settle = 0;
      return;
    end
    if (!m_valid) return;
    if (!enable) begin
      m_st = 0; m_dir = 0; m_step = 0; m_cyc = 0; m_el = 0; m_settle = 0;
      return;
    end
    if (m_st == 0) begin
      m_st = 1;
      if (m_amp == 0) m_amp = 1;
      m_cyc = 0; m_el = 0; m_step = 0;
      m_len = FMAX + 1 - m_freq;
      return;
    end
    tick = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    m_step = (tick && (m_el < m_amp)) ? 1 : 0;
    bound = 1'b0;
    if (tick) begin
      if (m_el + 1 == m_len) begin
        bound = 1'b1;
        m_el = 0;
        m_dir = 1 - m_dir;
        m_len = FMAX + 1 - m_freq;
      end else begin
        m_el++;
      end
    end
    app_m = (man_up || man_dn) && (m_st == 2 || m_st == 3);
    app_a = !(man_up || man_dn) && (Fplus || Fmin || Amin) && (m_st == 2);
    case (m_st)
      1: if (bound) m_st = 2;
      2: if (app_m || app_a) begin m_st = 3; m_settle = STK; end
      3: begin
        if (app_m) m_settle = STK;
        else if (tick) begin
          m_settle--;
          if (m_settle <= 0) m_st = 2;
        end
      end
      default: ;
    endcase
    up = 1'b0; dn = 1'b0;
    if (app_m) begin up = man_up && !man_dn; dn = man_dn && !man_up; end
    else if (app_a) begin up = Fplus && !Fmin; dn = Fmin && !Fplus; end
    if (up && m_freq < FMAX) m_freq++;
    if (dn && m_freq > FMIN) m_freq--;
    if (app_a && Amin && m_amp > 0) m_amp--;
  endtask

  // Model advances on every edge and queues the outputs expected after it.
  always @(posedge clk) begin
    model_step();
    if (m_valid)
      exp_q.push_back({2'(m_st), 4'(m_freq), 3'(m_amp), 1'(m_dir), 1'(m_step)});
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cyc_state", state, e[10:9]);
      check("cyc_busy", busy, (e[10:9] != 2'd0));
      check("cyc_freq", freq, e[8:5]);
      check("cyc_amp", amp, e[4:2]);
      check("cyc_dir", motor_dir, e[1]);
      check("cyc_step", motor_step, e[0]);
    end
  end

  // ---------------- driver ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int first_step, first_dir, steps, toggles, prev;

    // Reset values.
    reset = 1'b0;
    cycles(3);
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_freq", freq, 1);
    check("rst_amp", amp, 0);
    check("rst_dir", motor_dir, 0);
    check("rst_step", motor_step, 0);

    // Start-up: busy next cycle, amp kick-started, first step, first direction flip.
    reset = 1'b1;
    cycles(1);
    enable = 1'b1;
    cycles(1);
    check("start_busy", busy, 1);
    check("start_state", state, 1);
    check("start_amp", amp, 1);
    first_step = 0;
    first_dir = 0;
    for (int k = 1; k <= 80 && first_dir == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (motor_step && first_step == 0) first_step = k;
      if (motor_dir && first_dir == 0) first_dir = k;
    end
    check("start_first_step_cycle", first_step, 5);
    check("start_first_dir_cycle", first_dir, 61);
    check("start_to_rock", state, 2);

    // Auto freq +1 enters SETTLE; auto in SETTLE dropped; back to ROCK after 2 ticks.
    Fplus = 1'b1; cycles(1); Fplus = 1'b0;
    check("fplus_freq", freq, 2);
    check("fplus_settle", state, 3);
    Fmin = 1'b1; cycles(1); Fmin = 1'b0;
    check("settle_drop_fmin", freq, 2);
    cycles(8);
    check("settle_back_rock", state, 2);

    // Manual ups to 5 (also applied in SETTLE), then manual beats auto.
    man_up = 1'b1; cycles(3); man_up = 1'b0;
    check("man_up_to5", freq, 5);
    cycles(10);
    check("man_up_rock", state, 2);
    man_dn = 1'b1; Fplus = 1'b1; cycles(1); man_dn = 1'b0; Fplus = 1'b0;
    check("man_wins_freq", freq, 4);
    check("man_wins_settle", state, 3);
    cycles(10);

    // Saturation at F_MAX still enters SETTLE.
    man_up = 1'b1; cycles(11); man_up = 1'b0;
    cycles(10);
    check("freq_at_max", freq, 15);
    check("max_rock", state, 2);
    man_up = 1'b1; cycles(1); man_up = 1'b0;
    check("sat_freq", freq, 15);
    check("sat_settle", state, 3);
    cycles(10);

    // Amplitude to zero: swings continue without steps.
    Amin = 1'b1; cycles(1); Amin = 1'b0;
    check("amin_amp", amp, 0);
    steps = 0; toggles = 0; prev = motor_dir;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      steps += motor_step;
      if (motor_dir != prev) toggles++;
      prev = motor_dir;
    end
    check("amp0_steps", steps, 0);
    check("amp0_dir_toggles_ge2", (toggles >= 2), 1);

    // Disable mid-swing, then re-enable with amp=0.
    enable = 1'b0; cycles(1);
    check("dis_state", state, 0);
    check("dis_step", motor_step, 0);
    check("dis_dir", motor_dir, 0);
    check("dis_freq", freq, 15);
    check("dis_amp", amp, 0);
    enable = 1'b1; cycles(1);
    check("reen_amp", amp, 1);
    check("reen_state", state, 1);

    // Reset on the edge a step would fire (freq 15, amp 1: every tick steps).
    for (int i = 0; i < 20; i++) begin
      if (m_st != 0 && (m_cyc % TD) == TD - 1) break;
      @(negedge clk);
    end
    check("pre_reset_tick_found", ((m_cyc % TD) == TD - 1), 1);
    reset = 1'b0; cycles(1);
    check("abort_step", motor_step, 0);
    check("abort_state", state, 0);
    check("abort_freq", freq, 1);
    check("abort_amp", amp, 0);
    check("abort_dir", motor_dir, 0);
    check("abort_busy", busy, 0);

    // Random commands, enable drops and occasional resets.
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      man_up = ($urandom_range(0, 15) == 0);
      man_dn = ($urandom_range(0, 17) == 0);
      Fplus  = ($urandom_range(0, 7) == 0);
      Fmin   = ($urandom_range(0, 7) == 0);
      Amin   = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      reset = ($urandom_range(0, 799) != 0);
      cycles(1);
    end
    man_up = 1'b0; man_dn = 1'b0; Fplus = 1'b0; Fmin = 1'b0; Amin = 1'b0;
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
